core_ibex_ifetch_capture_fifo: RTL

- Parametrised successor to the passive ifetch monitor signal bundle; it actively captures fetch transactions instead of only exposing them.
- Samples every fetch handshake (valid && ready) and buffers addr/rdata/err/err_plus2 plus a sequence number in a FIFO, so the cosim agent can drain at its own pace.
- Sits in the DV core_ibex cosim agent between the probed ifetch signals and the monitor.
- Provides occupancy, drop counting and flush.

---
 rtl/core_ibex_ifetch_capture_fifo_if.sv | 68 ++++++
 rtl/core_ibex_ifetch_capture_fifo.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/core_ibex_ifetch_capture_fifo_if.sv
// Handshake bundle between the probed ifetch signals, the capture FIFO and its consumer.
// master: probe/consumer side; slave: FIFO side. IBEX_IFETCH_CAP_TIMESTAMP_EN adds out_ts_o.
interface core_ibex_ifetch_capture_fifo_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned SeqWidth  = 16
`ifdef IBEX_IFETCH_CAP_TIMESTAMP_EN
    ,
    parameter int unsigned TsWidth   = 32
`endif
);
    logic                 fetch_valid_i;
    logic                 fetch_ready_i;
    logic [AddrWidth-1:0] fetch_addr_i;
    logic [DataWidth-1:0] fetch_rdata_i;
    logic                 fetch_err_i;
    logic                 fetch_err_plus2_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [AddrWidth-1:0] out_addr_o;
    logic [DataWidth-1:0] out_rdata_o;
    logic                 out_err_o;
    logic                 out_err_plus2_o;
    logic [SeqWidth-1:0]  out_seq_o;
`ifdef IBEX_IFETCH_CAP_TIMESTAMP_EN
    logic [TsWidth-1:0]   out_ts_o;
`endif

    modport master (
        output fetch_valid_i,
        output fetch_ready_i,
        output fetch_addr_i,
        output fetch_rdata_i,
        output fetch_err_i,
        output fetch_err_plus2_i,
        output out_ready_i,
        input  out_valid_o,
        input  out_addr_o,
        input  out_rdata_o,
        input  out_err_o,
        input  out_err_plus2_o,
        input  out_seq_o
`ifdef IBEX_IFETCH_CAP_TIMESTAMP_EN
        ,
        input  out_ts_o
`endif
    );

    modport slave (
        input  fetch_valid_i,
        input  fetch_ready_i,
        input  fetch_addr_i,
        input  fetch_rdata_i,
        input  fetch_err_i,
        input  fetch_err_plus2_i,
        input  out_ready_i,
        output out_valid_o,
        output out_addr_o,
        output out_rdata_o,
        output out_err_o,
        output out_err_plus2_o,
        output out_seq_o
`ifdef IBEX_IFETCH_CAP_TIMESTAMP_EN
        ,
        output out_ts_o
`endif
    );
endinterface

// File: rtl/core_ibex_ifetch_capture_fifo.sv
// Captures every fetch handshake (valid && ready) into a FIFO tagged with a sequence number.
// Ports: clk_i, rst_ni (async low), flush_i, bus (slave: fetch_* in, out_* head),
// level_o occupancy, overflow_o sticky drop flag, drop_cnt_o saturating drop count.
// Optional macro IBEX_IFETCH_CAP_TIMESTAMP_EN: per-entry cycle timestamp on out_ts_o.
module core_ibex_ifetch_capture_fifo #(
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned Depth        = 8,
    parameter int unsigned SeqWidth     = 16,
    parameter int unsigned DropCntWidth = 8
`ifdef IBEX_IFETCH_CAP_TIMESTAMP_EN
    ,
    parameter int unsigned TsWidth      = 32
`endif
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    core_ibex_ifetch_capture_fifo_if.slave bus,
    output logic [$clog2(Depth):0]      level_o,
    output logic                        overflow_o,
    output logic [DropCntWidth-1:0]     drop_cnt_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] rdata;
        logic                 err;
        logic                 err_plus2;
        logic [SeqWidth-1:0]  seq;
`ifdef IBEX_IFETCH_CAP_TIMESTAMP_EN
        logic [TsWidth-1:0]   ts;
`endif
    } entry_t;

    entry_t                  mem_q [Depth];
    entry_t                  wr_entry;
    entry_t                  head;
    logic [PtrW-1:0]         wr_ptr_q;
    logic [PtrW-1:0]         rd_ptr_q;
    logic [LvlW-1:0]         level_q;
    logic [LvlW-1:0]         level_d;
    logic [SeqWidth-1:0]     seq_q;
    logic                    ovf_q;
    logic [DropCntWidth-1:0] drop_q;
    logic                    cap;
    logic                    pop;
    logic                    full;
    logic                    push;
    logic                    drop;
    logic                    valid;
`ifdef IBEX_IFETCH_CAP_TIMESTAMP_EN
    logic [TsWidth-1:0]      ts_q;
`endif

    assign cap   = bus.fetch_valid_i & bus.fetch_ready_i;
    assign valid = (level_q != '0);
    assign pop   = valid & bus.out_ready_i;
    assign full  = (level_q == LvlW'(Depth));

    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    assign push = cap & ~flush_i & (~full | pop);
    assign drop = cap & ~flush_i & full & ~pop;

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        wr_entry           = '0;
        wr_entry.addr      = bus.fetch_addr_i;
        wr_entry.rdata     = bus.fetch_rdata_i;
        wr_entry.err       = bus.fetch_err_i;
        wr_entry.err_plus2 = bus.fetch_err_plus2_i;
        wr_entry.seq       = seq_q;
`ifdef IBEX_IFETCH_CAP_TIMESTAMP_EN
        wr_entry.ts        = ts_q;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            seq_q    <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            // Sequence advances on every capture, stored, dropped or flushed.
            if (cap) seq_q <= seq_q + SeqWidth'(1);
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
                level_q <= level_d;
            end
            if (drop) begin
                ovf_q <= 1'b1;
                if (!(&drop_q)) drop_q <= drop_q + DropCntWidth'(1);
            end
        end
    end

    // Payload storage needs no reset; reads are masked while empty.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

`ifdef IBEX_IFETCH_CAP_TIMESTAMP_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ts_q <= '0;
        else         ts_q <= ts_q + TsWidth'(1);
    end
`endif

    assign head = valid ? mem_q[rd_ptr_q] : '0;

    assign bus.out_valid_o     = valid;
    assign bus.out_addr_o      = head.addr;
    assign bus.out_rdata_o     = head.rdata;
    assign bus.out_err_o       = head.err;
    assign bus.out_err_plus2_o = head.err_plus2;
    assign bus.out_seq_o       = head.seq;
`ifdef IBEX_IFETCH_CAP_TIMESTAMP_EN
    assign bus.out_ts_o        = head.ts;
`endif

    assign level_o    = level_q;
    assign overflow_o = ovf_q;
    assign drop_cnt_o = drop_q;
endmodule
